// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU (control decoder + core) between the execute stage (port 0)
// and the branch/address unit (port 1), with valid/ready handshakes on both sides.
module alu_share_arbiter #(
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [3:0]          req_alu_op,
    input  logic [5:0]          req_funct3,
    input  logic [13:0]         req_funct7,
    input  logic [2*XLEN-1:0]   req_a,
    input  logic [2*XLEN-1:0]   req_b,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [XLEN-1:0]     rsp_result,
    output logic                rsp_zero,
    output logic                rsp_err,
    output logic [1:0]          alu_op_o,
    output logic [2:0]          funct3_o,
    output logic [6:0]          funct7_o,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    input  logic [3:0]          alu_ctrl_i,
    input  logic [XLEN-1:0]     alu_result,
    input  logic                alu_zero
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        alu_op_q;
    logic [2:0]        funct3_q;
    logic [6:0]        funct7_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic              err_q;

    logic              gnt_idx_s;
    logic              accept_s;
    logic              rsp_fire_s;

    // Round-robin grant: a tie goes to the port that did not win last time.
    always_comb begin
        gnt_idx_s = 1'b0;
        if (req_valid == 2'b11) begin
            gnt_idx_s = ~last_grant_q;
        end else if (req_valid[1]) begin
            gnt_idx_s = 1'b1;
        end else begin
            gnt_idx_s = 1'b0;
        end
    end

    assign accept_s   = (state_q == S_IDLE) && (req_valid != 2'b00) && !rst;
    assign rsp_fire_s = (state_q == S_RESP) && rsp_ready[owner_q] && !rst;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_EXEC;
                else          state_d = S_IDLE;
            end
            S_EXEC: begin
                if (cnt_q == {CW{1'b0}}) state_d = S_RESP;
                else                     state_d = S_EXEC;
            end
            S_RESP: begin
                if (rsp_fire_s) state_d = S_IDLE;
                else            state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake strobes, held low throughout reset.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (rst) begin
            req_ready = 2'b00;
            rsp_valid = 2'b00;
        end else if (accept_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else if (state_q == S_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end else begin
            req_ready = 2'b00;
            rsp_valid = 2'b00;
        end
    end

    // Drive regs, latency counter, response capture and arbitration history.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= {CW{1'b0}};
            alu_op_q     <= 2'b00;
            funct3_q     <= 3'b000;
            funct7_q     <= 7'b0000000;
            a_q          <= {XLEN{1'b0}};
            b_q          <= {XLEN{1'b0}};
            result_q     <= {XLEN{1'b0}};
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (accept_s) begin
            owner_q  <= gnt_idx_s;
            cnt_q    <= CW'(ALU_LAT - 1);
            alu_op_q <= gnt_idx_s ? req_alu_op[3:2]     : req_alu_op[1:0];
            funct3_q <= gnt_idx_s ? req_funct3[5:3]     : req_funct3[2:0];
            funct7_q <= gnt_idx_s ? req_funct7[13:7]    : req_funct7[6:0];
            a_q      <= gnt_idx_s ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
            b_q      <= gnt_idx_s ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
        end else if (state_q == S_EXEC) begin
            if (cnt_q != {CW{1'b0}}) begin
                cnt_q <= cnt_q - CW'(1);
            end else begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
                err_q    <= (alu_ctrl_i == 4'hF);
            end
        end else if (rsp_fire_s) begin
            last_grant_q <= owner_q;
        end
    end

    assign alu_op_o   = alu_op_q;
    assign funct3_o   = funct3_q;
    assign funct7_o   = funct7_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU decoder/core closes the loop for
// a single-cycle instance and a three-cycle-latency instance.
module tb_alu_share_arbiter;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_valid3 = 2'b00;
    logic [3:0]        req_alu_op = 4'b0000;
    logic [5:0]        req_funct3 = 6'b000000;
    logic [13:0]       req_funct7 = 14'b0;
    logic [2*XLEN-1:0] req_a = '0;
    logic [2*XLEN-1:0] req_b = '0;
    logic [1:0]        rsp_ready = 2'b00;
    logic [1:0]        rsp_ready3 = 2'b00;

    logic [1:0]      req_ready, rsp_valid, alu_op_o;
    logic [XLEN-1:0] rsp_result, alu_a, alu_b, alu_result;
    logic            rsp_zero, rsp_err, alu_zero;
    logic [2:0]      funct3_o;
    logic [6:0]      funct7_o;
    logic [3:0]      alu_ctrl;

    logic [1:0]      req_ready3, rsp_valid3, alu_op_o3;
    logic [XLEN-1:0] rsp_result3, alu_a3, alu_b3, alu_result3;
    logic            rsp_zero3, rsp_err3, alu_zero3;
    logic [2:0]      funct3_o3;
    logic [6:0]      funct7_o3;
    logic [3:0]      alu_ctrl3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] dec_f(input logic [1:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
        case (op)
            2'b00: return 4'b0010;
            2'b01: return 4'b0110;
            2'b10: begin
                case (f3)
                    3'b000:  return (f7 == 7'h20) ? 4'b0110 : 4'b0010;
                    3'b111:  return 4'b0000;
                    3'b110:  return 4'b0001;
                    default: return 4'b1111;
                endcase
            end
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] exe_f(input logic [3:0] c, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_ctrl    = dec_f(alu_op_o, funct3_o, funct7_o);
    assign alu_result  = exe_f(alu_ctrl, alu_a, alu_b);
    assign alu_zero    = (alu_result == 32'd0);
    assign alu_ctrl3   = dec_f(alu_op_o3, funct3_o3, funct7_o3);
    assign alu_result3 = exe_f(alu_ctrl3, alu_a3, alu_b3);
    assign alu_zero3   = (alu_result3 == 32'd0);

    alu_share_arbiter #(.XLEN(XLEN), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_op_o(alu_op_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl_i(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    alu_share_arbiter #(.XLEN(XLEN), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_zero(rsp_zero3), .rsp_err(rsp_err3),
        .alu_op_o(alu_op_o3), .funct3_o(funct3_o3), .funct7_o(funct7_o3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl_i(alu_ctrl3),
        .alu_result(alu_result3), .alu_zero(alu_zero3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int p, input logic [1:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b);
        if (p == 0) begin
            req_alu_op[1:0] = op; req_funct3[2:0] = f3; req_funct7[6:0] = f7;
            req_a[XLEN-1:0] = a;  req_b[XLEN-1:0] = b;
        end else begin
            req_alu_op[3:2] = op; req_funct3[5:3] = f3; req_funct7[13:7] = f7;
            req_a[2*XLEN-1:XLEN] = a; req_b[2*XLEN-1:XLEN] = b;
        end
    endtask

    initial begin
        // Reset: handshakes forced low even with requests pending.
        req_valid = 2'b01;
        tick(); tick();
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_result", 64'(rsp_result), 64'h0);
        check("rst_alu_a", 64'(alu_a), 64'h0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // 1) p0 R-type add 5+7.
        set_port(0, 2'b10, 3'b000, 7'h00, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1 check("t1_req_ready_c0", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        check("t1_exec_req_ready", 64'(req_ready), 64'h0);
        check("t1_exec_rsp_valid", 64'(rsp_valid), 64'h0);
        check("t1_alu_a", 64'(alu_a), 64'd5);
        check("t1_alu_b", 64'(alu_b), 64'd7);
        tick();
        check("t1_rsp_valid_c2", 64'(rsp_valid), 64'h1);
        check("t1_result", 64'(rsp_result), 64'd12);
        check("t1_zero", 64'(rsp_zero), 64'h0);
        check("t1_err", 64'(rsp_err), 64'h0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("t1_done", 64'(rsp_valid), 64'h0);

        // 2) p1 sub 9-9 -> zero; 4) response held with rsp_ready low / non-owner ready.
        set_port(1, 2'b01, 3'b000, 7'h00, 32'd9, 32'd9);
        req_valid = 2'b10;
        #1 check("t2_req_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        tick();
        check("t2_rsp_valid", 64'(rsp_valid), 64'h2);
        check("t2_result", 64'(rsp_result), 64'h0);
        check("t2_zero", 64'(rsp_zero), 64'h1);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            rsp_ready = (i == 2) ? 2'b01 : 2'b00;
            tick();
            check("t4_hold_valid", 64'(rsp_valid), 64'h2);
            check("t4_hold_result", 64'(rsp_result), 64'h0);
            check("t4_hold_zero", 64'(rsp_zero), 64'h1);
            check("t4_hold_req_ready", 64'(req_ready), 64'h0);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        check("t2_done", 64'(rsp_valid), 64'h0);

        // 3) both held, rsp_ready=11 -> grants 0,1,0,1 (p0: 100+1, p1: 50-8).
        set_port(0, 2'b00, 3'b000, 7'h00, 32'd100, 32'd1);
        set_port(1, 2'b01, 3'b000, 7'h00, 32'd50, 32'd8);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 check("t3_grant", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            tick();
            check("t3_rsp_port", 64'(rsp_valid), (k % 2 == 0) ? 64'h1 : 64'h2);
            check("t3_result", 64'(rsp_result), (k % 2 == 0) ? 64'd101 : 64'd42);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        // 5) unsupported R-type funct3 -> err, response still delivered.
        set_port(0, 2'b10, 3'b001, 7'h00, 32'd3, 32'd4);
        req_valid = 2'b01;
        #1 check("t5_req_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        tick();
        check("t5_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t5_err", 64'(rsp_err), 64'h1);
        check("t5_result", 64'(rsp_result), 64'hDEAD_BEEF);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // 6) reset during EXEC; last winner was p0, so only reset makes p0 win the tie.
        set_port(1, 2'b00, 3'b000, 7'h00, 32'd1, 32'd2);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        check("t6_in_exec_a", 64'(alu_a), 64'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("t6_rst_req_ready", 64'(req_ready), 64'h0);
        check("t6_rst_alu_a", 64'(alu_a), 64'h0);
        check("t6_rst_alu_b", 64'(alu_b), 64'h0);
        check("t6_rst_result", 64'(rsp_result), 64'h0);
        check("t6_rst_err", 64'(rsp_err), 64'h0);
        rst = 1'b0;
        tick();
        check("t6_no_rsp", 64'(rsp_valid), 64'h0);
        set_port(0, 2'b00, 3'b000, 7'h00, 32'd30, 32'd12);
        req_valid = 2'b11;
        #1 check("t6_tie_p0", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        tick();
        check("t6_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t6_result", 64'(rsp_result), 64'd42);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // 7) ALU_LAT=3 instance: response at T+4, drive regs stable meanwhile.
        set_port(0, 2'b00, 3'b000, 7'h00, 32'd20, 32'd22);
        req_valid3 = 2'b01;
        #1 check("t7_req_ready", 64'(req_ready3), 64'h1);
        tick();
        req_valid3 = 2'b00;
        set_port(0, 2'b01, 3'b000, 7'h00, 32'd77, 32'd66);
        for (int k = 1; k <= 3; k++) begin
            check("t7_no_rsp", 64'(rsp_valid3), 64'h0);
            check("t7_alu_a", 64'(alu_a3), 64'd20);
            check("t7_alu_b", 64'(alu_b3), 64'd22);
            tick();
        end
        check("t7_rsp_valid", 64'(rsp_valid3), 64'h1);
        check("t7_result", 64'(rsp_result3), 64'd42);
        rsp_ready3 = 2'b01;
        tick();
        rsp_ready3 = 2'b00;
        check("t7_done", 64'(rsp_valid3), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
